// File: rtl/spi_slave_responder_pkg.sv
// Shared SPI definitions: word size, mode, and the responder FSM state type.
package spi_slave_responder_pkg;

    localparam int unsigned SPI_DATA_W = 8;
    localparam logic        SPI_CPOL   = 1'b0;
    localparam logic        SPI_CPHA   = 1'b0;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } spi_state_e;

endpackage

// File: rtl/spi_slave_responder_sync_edge.sv
// Synchroniser for one asynchronous pin plus registered rise/fall detection.
module spi_slave_responder_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Edge pulses are registered, so level is taken from the history flop to stay aligned.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        hist_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~hist_q;
        fall_d = ~sync_q[STAGES-1] & hist_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = hist_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled pins, MSB-first rx deserialiser, tx serialiser, rx handshake.
module spi_slave_responder
    import spi_slave_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CNT_W     = $clog2(DATA_W);
    localparam int unsigned FLUSH_CYC = SYNC_STAGES + 2;
    localparam int unsigned FL_W      = $clog2(FLUSH_CYC + 1);

    logic ss_level, ss_rise, ss_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    spi_slave_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .rst(rst), .d(ss), .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );
    spi_slave_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst(rst), .d(sclk), .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_slave_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst(rst), .d(mosi), .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              arm_q, arm_d;
    logic [FL_W-1:0]   flush_q, flush_d;
    logic              primed;

    // A frame may only start once ss has been seen high with the sync chain flushed of reset values.
    assign primed = (flush_q == FL_W'(FLUSH_CYC));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;
        flush_d     = primed ? flush_q : flush_q + FL_W'(1);
        arm_d       = arm_q | (primed & ss_level);

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (ss_fall && arm_q) begin
                    tx_shift_d = tx_data;
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (ss_rise) begin
                    state_d     = S_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_level};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d  = {rx_shift_q[DATA_W-2:0], mosi_level};
                        overrun_d  = rx_valid_q & ~rx_ack;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    tx_shift_d = (bit_cnt_q == '0) ? tx_data : {tx_shift_q[DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            arm_q       <= 1'b0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            arm_q       <= arm_d;
            flush_q     <= flush_d;
        end
    end

    assign miso      = (state_q == S_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
    assign busy      = (state_q == S_ACTIVE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: directed scenarios plus random frames against a word-level model.
module tb_spi_slave_responder;

    localparam int unsigned SYNC = 2;
    localparam int unsigned HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ss = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned ovr_cnt = 0;
    int unsigned ferr_cnt = 0;

    // Word-level reference state
    logic [7:0]  m_data = 8'h00;
    logic        m_valid = 1'b0;
    int unsigned m_ovr = 0;
    int unsigned m_ferr = 0;

    spi_slave_responder #(.DATA_W(8), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .overrun(overrun), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun)   ovr_cnt++;
        if (frame_err) ferr_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        ss = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic frame_end();
        wait_clks(HALF);
        ss = 1'b1;
        wait_clks(HALF);
    endtask

    // Mode-0 master: mosi set while sclk low, miso sampled at the sclk rising edge.
    task automatic xfer(input logic [7:0] mo, input int unsigned nbits, input logic [7:0] next_tx,
                        input bit has_next, input bit lat_chk, input bit ack_same, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - int'(nbits); i--) begin
            mosi = mo[i];
            wait_clks(HALF);
            sclk = 1'b1;
            mi[i] = miso;
            if (i == 0) begin
                if (has_next) tx_data = next_tx;
                for (int unsigned n = 1; n <= SYNC + 2; n++) begin
                    @(posedge clk);
                    #1;
                    if (lat_chk && n == SYNC + 1) check("lat_early", rx_valid, 1'b0);
                    if (lat_chk && n == SYNC + 2) check("lat_valid", rx_valid, 1'b1);
                    if (ack_same && n == SYNC + 1) rx_ack = 1'b1;
                    if (ack_same && n == SYNC + 2) rx_ack = 1'b0;
                end
                wait_clks(HALF - SYNC - 2);
            end else begin
                wait_clks(HALF);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic model_word(input logic [7:0] w, input bit acked);
        if (m_valid && !acked) m_ovr++;
        m_valid = 1'b1;
        m_data  = w;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_rx_data"}, rx_data, m_data);
        check({tag, "_rx_valid"}, rx_valid, m_valid);
        check({tag, "_overruns"}, ovr_cnt, m_ovr);
        check({tag, "_frame_errs"}, ferr_cnt, m_ferr);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            sclk = ~sclk;
            mosi = ~mosi;
        end
        sclk = 1'b0;
        mosi = 1'b0;
        m_data  = 8'h00;
        m_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] mi;
        logic [7:0] mi2;

        // Reset with pins toggling
        apply_reset();
        check("rst_miso", miso, 1'b0);
        check("rst_busy", busy, 1'b0);
        check_state("rst");
        rst = 1'b1;
        wait_clks(20);

        // Single word
        tx_data = 8'h3C;
        frame_start();
        xfer(8'hA5, 8, 8'h00, 1'b0, 1'b1, 1'b0, mi);
        model_word(8'hA5, 1'b0);
        check("single_busy", busy, 1'b1);
        frame_end();
        check("single_miso", mi, 8'h3C);
        check_state("single");
        ack_pulse();
        check("single_ack_clears", rx_valid, 1'b0);

        // Two words, tx reload at the boundary, overrun on the second
        tx_data = 8'h81;
        frame_start();
        xfer(8'h12, 8, 8'hE7, 1'b1, 1'b0, 1'b0, mi);
        model_word(8'h12, 1'b0);
        xfer(8'h34, 8, 8'h00, 1'b0, 1'b0, 1'b0, mi2);
        model_word(8'h34, 1'b0);
        frame_end();
        check("b2b_miso0", mi, 8'h81);
        check("b2b_miso1", mi2, 8'hE7);
        check_state("b2b");

        // Abort after 5 bits
        frame_start();
        xfer(8'hFF, 5, 8'h00, 1'b0, 1'b0, 1'b0, mi);
        frame_end();
        m_ferr++;
        check_state("abort");
        ack_pulse();
        tx_data = 8'h0F;
        frame_start();
        xfer(8'h5A, 8, 8'h00, 1'b0, 1'b0, 1'b0, mi);
        model_word(8'h5A, 1'b0);
        frame_end();
        check("after_abort_miso", mi, 8'h0F);
        check_state("after_abort");
        ack_pulse();

        // Reset mid-frame, released with ss high
        frame_start();
        xfer(8'hFF, 4, 8'h00, 1'b0, 1'b0, 1'b0, mi);
        ss = 1'b1;
        apply_reset();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_miso", miso, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check_state("midrst");
        wait_clks(20);
        tx_data = 8'h96;
        frame_start();
        xfer(8'hC3, 8, 8'h00, 1'b0, 1'b0, 1'b0, mi);
        model_word(8'hC3, 1'b0);
        frame_end();
        check("midrst_next_miso", mi, 8'h96);
        check_state("midrst_next");
        ack_pulse();

        // Reset released with ss still low: nothing is received until a fresh ss fall
        ss = 1'b0;
        wait_clks(HALF);
        apply_reset();
        rst = 1'b1;
        wait_clks(20);
        xfer(8'h99, 8, 8'h00, 1'b0, 1'b0, 1'b0, mi);
        check("ss_low_rel_busy", busy, 1'b0);
        frame_end();
        check_state("ss_low_rel");

        // Word completes in the same cycle as rx_ack while rx_valid=1
        frame_start();
        xfer(8'h11, 8, 8'h00, 1'b0, 1'b0, 1'b0, mi);
        model_word(8'h11, 1'b0);
        frame_end();
        frame_start();
        xfer(8'h77, 8, 8'h00, 1'b0, 1'b0, 1'b1, mi);
        model_word(8'h77, 1'b1);
        frame_end();
        check_state("ack_same");
        ack_pulse();

        // Random frames
        for (int unsigned f = 0; f < 10; f++) begin
            int unsigned nw;
            logic [7:0]  txw [3];
            logic [7:0]  mow [3];
            nw = $urandom_range(1, 3);
            for (int unsigned k = 0; k < 3; k++) begin
                txw[k] = 8'($urandom);
                mow[k] = 8'($urandom);
            end
            tx_data = txw[0];
            frame_start();
            for (int unsigned k = 0; k < nw; k++) begin
                xfer(mow[k], 8, (k + 1 < 3) ? txw[k + 1] : 8'h00, (k + 1 < nw), 1'b0, 1'b0, mi);
                model_word(mow[k], 1'b0);
                check("rnd_miso", mi, txw[k]);
                check_state("rnd");
                if ($urandom_range(0, 1) == 1) ack_pulse();
            end
            frame_end();
            check_state("rnd_end");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
